// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX-stage divide initiator and the iterative divider.
interface div_issue_ctrl_if;
    logic        div_start;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    modport master (
        output div_start, div_sign, div_a, div_b,
        input  div_quotient, div_remainder, div_done
    );

    modport slave (
        input  div_start, div_sign, div_a, div_b,
        output div_quotient, div_remainder, div_done
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU initiator: launches the iterative divider, stalls EX until it
// completes, then issues a single HI/LO write as the instruction leaves EX.
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req,
    input  logic        ex_div_sign,
    input  logic [31:0] ex_op_a,
    input  logic [31:0] ex_op_b,
    input  logic        flush,
    input  logic        pipe_hold,
    output logic        div_stall,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_timeout,
    div_issue_ctrl_if.master div
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q, b_q, hi_q, lo_q;
    logic          sign_q;
    logic          accept, capture, start;

    // flush is checked first in every state so it wins over done, hold and timeout
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        div_stall   = 1'b0;
        hilo_we     = 1'b0;
        div_timeout = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_div_req && !flush) begin
                    div_stall = 1'b1;
                    accept    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                start     = 1'b1;
                div_stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (div.div_done) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    div_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!pipe_hold) begin
                    hilo_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= ex_op_a;
                b_q    <= ex_op_b;
                sign_q <= ex_div_sign;
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture) begin
                lo_q <= div.div_quotient;
                hi_q <= div.div_remainder;
            end
        end
    end

    assign div.div_start = start;
    assign div.div_sign  = sign_q;
    assign div.div_a     = a_q;
    assign div.div_b     = b_q;
    assign hi_wdata      = hi_q;
    assign lo_wdata      = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural 34-cycle divider stub, table-driven
// single operations plus hand-written flush, hold, back-to-back, timeout and reset sequences.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_req = 1'b0;
    logic        ex_div_sign = 1'b0;
    logic [31:0] ex_op_a = '0;
    logic [31:0] ex_op_b = '0;
    logic        flush = 1'b0;
    logic        pipe_hold = 1'b0;
    logic        div_stall, hilo_we, div_timeout;
    logic [31:0] hi_wdata, lo_wdata;

    int passed = 0;
    int total  = 0;

    div_issue_ctrl_if dbus ();

    div_issue_ctrl #(.TIMEOUT_CYCLES(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_div_req (ex_div_req),
        .ex_div_sign(ex_div_sign),
        .ex_op_a    (ex_op_a),
        .ex_op_b    (ex_op_b),
        .flush      (flush),
        .pipe_hold  (pipe_hold),
        .div_stall  (div_stall),
        .hilo_we    (hilo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata),
        .div_timeout(div_timeout),
        .div        (dbus)
    );

    always #5 clk = ~clk;

    // Divider stub: samples operands on first start cycle, done on the 34th start-high cycle.
    logic [5:0]  sc = '0;
    logic [31:0] sa = '0, sb = '0;
    logic        never_done = 1'b0;

    always_ff @(posedge clk) begin
        if (!dbus.div_start) begin
            sc <= '0;
        end else begin
            if (sc == 6'd0) begin
                sa <= dbus.div_a;
                sb <= dbus.div_b;
            end
            if (sc != 6'd63) sc <= sc + 6'd1;
        end
    end

    assign dbus.div_done = dbus.div_start && (sc == 6'd33) && !never_done;

    always_comb begin
        dbus.div_quotient  = '1;
        dbus.div_remainder = sa;
        if (sb != 32'd0) begin
            if (dbus.div_sign) begin
                dbus.div_quotient  = $signed(sa) / $signed(sb);
                dbus.div_remainder = $signed(sa) % $signed(sb);
            end else begin
                dbus.div_quotient  = sa / sb;
                dbus.div_remainder = sa % sb;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] lo, input logic [31:0] hi);
        int n;
        @(posedge clk); #1;
        ex_op_a = a; ex_op_b = b; ex_div_sign = sgn; ex_div_req = 1'b1;
        @(negedge clk);
        n = 0;
        while (div_stall && n < 100) begin
            n++;
            if (n == 2) begin
                check("run_start", {31'd0, dbus.div_start}, 32'd1);
                check("run_div_a", dbus.div_a, a);
                check("run_div_b", dbus.div_b, b);
            end
            @(negedge clk);
        end
        check("stall_len", n, 32'd35);
        check("done_we", {31'd0, hilo_we}, 32'd1);
        check("done_lo", lo_wdata, lo);
        check("done_hi", hi_wdata, hi);
        check("done_sign", {31'd0, dbus.div_sign}, {31'd0, sgn});
        check("done_start", {31'd0, dbus.div_start}, 32'd0);
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(negedge clk);
        check("we_once", {31'd0, hilo_we}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, gap, pulses;
        logic seen;

        vecs[0] = '{a: 32'hFFFFFFF9, b: 32'd2,  sgn: 1'b1, lo: 32'hFFFFFFFD, hi: 32'hFFFFFFFF};
        vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h10, sgn: 1'b0, lo: 32'h0FFFFFFF, hi: 32'h0000000F};
        vecs[2] = '{a: 32'd100,      b: 32'd7,  sgn: 1'b0, lo: 32'd14,       hi: 32'd2};
        vecs[3] = '{a: 32'd5,        b: 32'd0,  sgn: 1'b0, lo: 32'hFFFFFFFF, hi: 32'd5};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_start", {31'd0, dbus.div_start}, 32'd0);
        check("rst_we", {31'd0, hilo_we}, 32'd0);
        check("rst_lo", lo_wdata, 32'd0);

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lo, vecs[i].hi);

        // Flush in RUN cycle 10
        @(posedge clk); #1;
        ex_op_a = 32'd1000; ex_op_b = 32'd3; ex_div_sign = 1'b0; ex_div_req = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_run_start", {31'd0, dbus.div_start}, 32'd1);
        check("flush_we", {31'd0, hilo_we}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; ex_div_req = 1'b0;
        @(negedge clk);
        check("flush_start_low", {31'd0, dbus.div_start}, 32'd0);
        check("flush_stall_low", {31'd0, div_stall}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_we) seen = 1'b1;
        end
        check("flush_no_write", {31'd0, seen}, 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

        // pipe_hold across done: DONE held 5 cycles
        @(posedge clk); #1;
        ex_op_a = 32'd50; ex_op_b = 32'd6; ex_div_sign = 1'b0; ex_div_req = 1'b1;
        repeat (33) @(posedge clk);
        #1 pipe_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_we", {31'd0, hilo_we}, 32'd0);
            check("hold_stall", {31'd0, div_stall}, 32'd0);
            check("hold_lo", lo_wdata, 32'd8);
            check("hold_hi", hi_wdata, 32'd2);
            @(posedge clk); #1;
        end
        pipe_hold = 1'b0;
        @(negedge clk);
        check("hold_release_we", {31'd0, hilo_we}, 32'd1);
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(negedge clk);
        check("hold_we_once", {31'd0, hilo_we}, 32'd0);

        // Flush while held in DONE
        @(posedge clk); #1;
        ex_op_a = 32'd9; ex_op_b = 32'd4; ex_div_sign = 1'b0; ex_div_req = 1'b1;
        repeat (33) @(posedge clk);
        #1 pipe_hold = 1'b1;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("hold_flush_we", {31'd0, hilo_we}, 32'd0);
        check("hold_flush_lo", lo_wdata, 32'd2);
        @(posedge clk); #1;
        flush = 1'b0; pipe_hold = 1'b0; ex_div_req = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (hilo_we) seen = 1'b1;
        end
        check("hold_flush_no_write", {31'd0, seen}, 32'd0);
        check("hold_flush_stall", {31'd0, div_stall}, 32'd0);

        // Back-to-back: 20/3 then -20/3 signed
        @(posedge clk); #1;
        ex_op_a = 32'd20; ex_op_b = 32'd3; ex_div_sign = 1'b0; ex_div_req = 1'b1;
        pulses = 0;
        n = 0;
        @(negedge clk);
        while (!hilo_we && n < 100) begin n++; @(negedge clk); end
        if (hilo_we) pulses++;
        check("b2b1_lo", lo_wdata, 32'd6);
        check("b2b1_hi", hi_wdata, 32'd2);
        gap = dbus.div_start ? 0 : 1;
        @(posedge clk); #1;
        ex_op_a = 32'hFFFFFFEC; ex_op_b = 32'd3; ex_div_sign = 1'b1;
        @(negedge clk);
        while (!dbus.div_start && gap < 10) begin gap++; @(negedge clk); end
        check("b2b_start_gap", gap, 32'd2);
        n = 0;
        while (!hilo_we && n < 100) begin n++; @(negedge clk); end
        if (hilo_we) pulses++;
        check("b2b2_lo", lo_wdata, 32'hFFFFFFFA);
        check("b2b2_hi", hi_wdata, 32'hFFFFFFFE);
        check("b2b2_sign", {31'd0, dbus.div_sign}, 32'd1);
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(negedge clk);
        check("b2b_pulses", pulses, 32'd2);
        check("b2b_we_once", {31'd0, hilo_we}, 32'd0);

        // Divider never completes: watchdog abort after 48 RUN cycles
        never_done = 1'b1;
        @(posedge clk); #1;
        ex_op_a = 32'd1; ex_op_b = 32'd1; ex_div_sign = 1'b1; ex_div_req = 1'b1;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            if (dbus.div_start) n++;
            if (hilo_we) seen = 1'b1;
            if (div_timeout) break;
            @(negedge clk);
        end
        check("to_pulse", {31'd0, div_timeout}, 32'd1);
        check("to_run_cycles", n, 32'd48);
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(negedge clk);
        check("to_pulse_once", {31'd0, div_timeout}, 32'd0);
        check("to_idle_start", {31'd0, dbus.div_start}, 32'd0);
        check("to_no_write", {31'd0, seen | hilo_we}, 32'd0);
        never_done = 1'b0;

        // Reset mid-RUN
        @(posedge clk); #1;
        ex_op_a = 32'hFFFFFF00; ex_op_b = 32'd5; ex_div_sign = 1'b1; ex_div_req = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; ex_div_req = 1'b0;
        @(negedge clk);
        check("pre_rst_start", {31'd0, dbus.div_start}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_start", {31'd0, dbus.div_start}, 32'd0);
        check("mrst_stall", {31'd0, div_stall}, 32'd0);
        check("mrst_we", {31'd0, hilo_we}, 32'd0);
        check("mrst_timeout", {31'd0, div_timeout}, 32'd0);
        check("mrst_sign", {31'd0, dbus.div_sign}, 32'd0);
        check("mrst_a", dbus.div_a, 32'd0);
        check("mrst_b", dbus.div_b, 32'd0);
        check("mrst_lo", lo_wdata, 32'd0);
        check("mrst_hi", hi_wdata, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
